// File: rtl/als_sample_scheduler.sv
// als_sample_scheduler: periodic/on-demand PMOD ALS sampling with SPI timeout, display register and UART FIFO
`timescale 1ns/1ps
module als_sample_scheduler #(
  parameter int MUESTREO   = 10_000_000,
  parameter int TIMEOUT    = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_100m_i,
  input  logic        rst,
  input  logic        en_i,
  input  logic        req_i,
  output logic        spi_start_o,
  input  logic        spi_busy_i,
  input  logic        spi_done_i,
  input  logic [15:0] spi_data_i,
  output logic [7:0]  sample_o,
  output logic        sample_valid_o,
  output logic [7:0]  fifo_data_o,
  output logic        fifo_valid_o,
  input  logic        fifo_ready_i,
  output logic        timeout_o,
  output logic        overflow_o
);
  localparam int PW = $clog2(MUESTREO);
  localparam int TW = $clog2(TIMEOUT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PMAX = PW'(MUESTREO - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic pend_per, pend_req, go, tick, to_hit, push, pop, full, acc;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [7:0] last;
  logic unused_pad;
  assign unused_pad = ^{spi_data_i[15:13], spi_data_i[4:0]};
  always_comb begin
    go = (pend_per | pend_req) & ~spi_busy_i;
    tick = en_i && pcnt == PMAX;
    to_hit = state == WAIT && !spi_done_i && tcnt == TMAX;
    spi_start_o = state == START;
    sample_valid_o = state == CAPTURE;
    state_nx = state == IDLE  ? (go ? START : IDLE) :
               state == START ? WAIT :
               state == WAIT  ? (spi_done_i ? CAPTURE : (to_hit ? IDLE : WAIT)) : IDLE;
  end
  // extra pointer bit separates full from empty
  always_comb begin
    fifo_valid_o = wp != rp;
    full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    push = state == CAPTURE;
    pop = fifo_valid_o & fifo_ready_i;
    acc = push & (~full | pop);
    fifo_data_o = fifo_valid_o ? mem[rp[AW-1:0]] : last;
  end
  always_ff @(posedge clk_100m_i or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // a new request in the same cycle as the launch stays pending
  always_ff @(posedge clk_100m_i or negedge rst)
    if (!rst) begin
      pcnt <= '0;
      pend_per <= 1'b0;
      pend_req <= 1'b0;
      tcnt <= '0;
      sample_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      pcnt <= (!en_i || tick) ? '0 : pcnt + 1'b1;
      pend_per <= en_i & (tick | (pend_per & ~(state == IDLE & go)));
      pend_req <= req_i | (pend_req & ~(state == IDLE & go));
      tcnt <= state == START ? '0 : state == WAIT ? tcnt + 1'b1 : tcnt;
      if (state == WAIT && spi_done_i) sample_o <= spi_data_i[12:5];
      if (to_hit) timeout_o <= 1'b1;
    end
  always_ff @(posedge clk_100m_i or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      last <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (acc) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (pop) last <= mem[rp[AW-1:0]];
      if (push && full && !pop) overflow_o <= 1'b1;
    end
  always_ff @(posedge clk_100m_i)
    if (acc) mem[wp[AW-1:0]] <= sample_o;
endmodule

// File: tb/tb_als_sample_scheduler.sv
// tb_als_sample_scheduler: scoreboard bench with SPI responder and queue-based FIFO reference
`timescale 1ns/1ps
module tb_als_sample_scheduler;
  localparam int MUESTREO = 2000, TIMEOUT = 64, DEPTH = 4, SPI_LAT = 40;
  logic clk = 0, rst = 0, en_i = 0, req_i = 0, spi_busy_i = 0, spi_done_i = 0, fifo_ready_i = 0;
  logic [15:0] spi_data_i = 0;
  logic spi_start_o, sample_valid_o, fifo_valid_o, timeout_o, overflow_o;
  logic [7:0] sample_o, fifo_data_o;
  int vectors = 0, miscompares = 0, cyc = 0, n_start = 0;
  logic silent = 0, rnd_frame = 0, start_flag = 0;
  logic [15:0] frame = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_last = 0, m_sample = 0, pend_v = 0;
  logic m_to = 0, m_ovf = 0, m_sv = 0, live = 0, pend_push = 0;
  int w = 0;

  als_sample_scheduler #(.MUESTREO(MUESTREO), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_100m_i(clk), .rst(rst), .en_i(en_i), .req_i(req_i), .spi_start_o(spi_start_o),
    .spi_busy_i(spi_busy_i), .spi_done_i(spi_done_i), .spi_data_i(spi_data_i),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o), .fifo_data_o(fifo_data_o),
    .fifo_valid_o(fifo_valid_o), .fifo_ready_i(fifo_ready_i), .timeout_o(timeout_o),
    .overflow_o(overflow_o));

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #1_000_000; $display("FAIL watchdog: run did not finish"); $fatal(1); end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SPI master model: busy for SPI_LAT cycles after a start, then a done pulse with the frame
  initial begin : spi
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      spi_done_i = 0;
      start_flag = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_busy_i = 0;
          if (!silent) begin
            spi_done_i = 1;
            spi_data_i = rnd_frame ? 16'($urandom) : frame;
          end
        end
      end
      if (spi_start_o) begin
        start_flag = 1;
        n_start++;
        if (cnt == 0) begin cnt = SPI_LAT; spi_busy_i = 1; end
      end
    end
  end

  // reference: a started transaction lives until done or TIMEOUT wait cycles; captures feed a queue FIFO
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      mq.delete(); exp_q.delete();
      m_last = 0; m_sample = 0; m_to = 0; m_ovf = 0; m_sv = 0; live = 0; pend_push = 0; w = 0;
    end else begin
      if (mq.size() > 0 && fifo_ready_i) m_last = mq.pop_front();
      if (pend_push) begin
        if (mq.size() < DEPTH) mq.push_back(pend_v);
        else m_ovf = 1;
      end
      pend_push = 0;
      m_sv = 0;
      if (live) begin
        if (spi_done_i) begin
          live = 0; pend_push = 1; m_sv = 1;
          pend_v = spi_data_i[12:5];
          m_sample = pend_v;
          exp_q.push_back(pend_v);
        end else begin
          w++;
          if (w == TIMEOUT) begin live = 0; m_to = 1; end
        end
      end
      if (start_flag) begin live = 1; w = 0; end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("fifo_valid", fifo_valid_o, mq.size() > 0);
      chk("fifo_data", fifo_data_o, mq.size() > 0 ? mq[0] : m_last);
      chk("timeout", timeout_o, m_to);
      chk("overflow", overflow_o, m_ovf);
      chk("sample_valid", sample_valid_o, m_sv);
      chk("sample", sample_o, m_sample);
      if (sample_valid_o) begin
        if (exp_q.size() == 0) chk("unexpected_sample", sample_valid_o, 0);
        else chk("scoreboard_sample", sample_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_req();
    @(posedge clk); #1 req_i = 1;
    @(posedge clk); #1 req_i = 0;
  endtask
  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
    @(posedge clk); #1;
  endtask
  task automatic wait_for(input int sel, input int lim, input string name, output int t);
    int k;
    k = 0; t = -1;
    while (k < lim) begin
      @(negedge clk);
      if ((sel == 0 && spi_start_o) || (sel == 1 && sample_valid_o) || (sel == 2 && timeout_o)) begin
        t = cyc;
        break;
      end
      k++;
    end
    if (t < 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: no event within %0d cycles", name, lim);
    end
  endtask
  task automatic chk_zero(input string p);
    chk({p, "_start"}, spi_start_o, 0);
    chk({p, "_sample"}, sample_o, 0);
    chk({p, "_sample_valid"}, sample_valid_o, 0);
    chk({p, "_fifo_data"}, fifo_data_o, 0);
    chk({p, "_fifo_valid"}, fifo_valid_o, 0);
    chk({p, "_timeout"}, timeout_o, 0);
    chk({p, "_overflow"}, overflow_o, 0);
  endtask

  initial begin
    int t0, t1, t2, n0;
    tick(3);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1; fifo_ready_i = 1; frame = 16'h0FE0; en_i = 1;
    wait_for(0, 2100, "t1_start_a", t1);
    wait_for(1, 100, "t1_sample", t0);
    chk("t1_sample_7f", sample_o, 8'h7F);
    wait_for(0, 2100, "t1_start_b", t2);
    chk("t1_period", t2 - t1, MUESTREO);
    n0 = n_start;
    at_cycle(t2 + 1979); pulse_req();
    at_cycle(t2 + 1995); pulse_req();
    at_cycle(t2 + 2005); pulse_req();
    at_cycle(t2 + 2015); pulse_req();
    at_cycle(t2 + 2200);
    chk("t3_collapsed_starts", n_start - n0, 2);
    wait_for(0, 2100, "t3_next_period", t0);
    chk("t3_period_kept", t0 - t2, 2 * MUESTREO);
    en_i = 0;
    tick(100);
    frame = 16'h1FE0;
    pulse_req();
    wait_for(0, 20, "t2_start", t0);
    wait_for(1, 100, "t2_sample", t1);
    chk("t2_latency", t1 - t0, SPI_LAT + 1);
    chk("t2_sample_ff", sample_o, 8'hFF);
    tick(20);
    silent = 1;
    pulse_req();
    wait_for(0, 20, "t4_start", t0);
    wait_for(2, 200, "t4_timeout", t1);
    chk("t4_timeout_latency", t1 - t0, TIMEOUT + 1);
    chk("t4_no_push", fifo_valid_o, 0);
    tick(5);
    silent = 0; frame = 16'h0AA0;
    pulse_req();
    wait_for(1, 100, "t4_recover", t1);
    chk("t4_recover_55", sample_o, 8'h55);
    tick(5);
    rnd_frame = 1; en_i = 1;
    repeat (8000) begin
      @(posedge clk); #1;
      req_i = $urandom_range(0, 99) == 0;
      fifo_ready_i = 1'($urandom_range(0, 1));
      en_i = ($urandom_range(0, 999) == 0) ? ~en_i : en_i;
    end
    req_i = 0; fifo_ready_i = 1; en_i = 0;
    tick(200);
    rnd_frame = 0; frame = 16'h1234;
    pulse_req();
    wait_for(0, 20, "t6_start", t0);
    tick(10);
    rst = 0;
    @(negedge clk);
    chk_zero("t6_reset");
    tick(2);
    rst = 1;
    tick(60);
    chk("t6_late_done_ignored", sample_o, 0);
    chk("t6_no_push", fifo_valid_o, 0);
    frame = 16'h0660;
    pulse_req();
    wait_for(1, 100, "t6_resume", t1);
    chk("t6_resume_33", sample_o, 8'h33);
    tick(5);
    fifo_ready_i = 0;
    tick(2);
    for (int v = 1; v <= 5; v++) begin
      frame = 16'(v) << 5;
      pulse_req();
      wait_for(1, 100, "t5_sample", t1);
      tick(2);
      if (v == 4) chk("t5_no_overflow_yet", overflow_o, 0);
    end
    @(negedge clk);
    chk("t5_overflow", overflow_o, 1);
    chk("t5_sample_05", sample_o, 8'h05);
    chk("t5_head", fifo_data_o, 8'h01);
    @(posedge clk); #1 fifo_ready_i = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t5_drain_valid", fifo_valid_o, 1);
      chk("t5_drain_data", fifo_data_o, i);
    end
    @(negedge clk);
    chk("t5_empty", fifo_valid_o, 0);
    chk("t5_hold_last", fifo_data_o, 8'h04);
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
